// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
//   Assembles sampled serial bits into a DATA_W-bit word (LSB first). It checks
//   parity (even/odd/mark/space) and one or two stop bits. Each completed frame
//   and its error flags are presented on a single-entry valid/ready output slot.
//   This block sits between the bit sampler and the RX FIFO/host interface.
//
// Optional feature: define FRAME_ERR_CNT_EN to add saturating parity/stop error
// counters (cnt_clr, par_err_cnt, stp_err_cnt ports).
//
// Ports
//   CLK, RST            clock, async active-low reset
//   start_det           start bit confirmed (pulse), frame begins
//   bit_vld, bit_val    sampled-bit strobe and value
//   par_en, par_type    parity present; 00 even, 01 odd, 10 mark, 11 space
//   stop2               two stop bits when 1
//   frame_data          assembled word
//   frame_vld/rdy       output handshake
//   par_err, stp_err    error flags of the presented frame (0 when !frame_vld)
//   ovr_err             pulse: completed frame dropped, slot occupied
//   busy                receiving a frame
//   cnt_clr, par_err_cnt, stp_err_cnt   error counters (FRAME_ERR_CNT_EN only)
module uart_rx_frame_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_det,
  input  logic              bit_vld,
  input  logic              bit_val,
  input  logic              par_en,
  input  logic [1:0]        par_type,
  input  logic              stop2,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_vld,
  input  logic              frame_rdy,
  output logic              par_err,
  output logic              stp_err,
  output logic              ovr_err,
  output logic              busy
`ifdef FRAME_ERR_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  stp_err_cnt
`endif
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic              run_par, perr_q, serr_q;
  logic              pen_q, s2_q;
  logic [1:0]        pt_q;
  logic              done, exp_par, final_serr, load;

  always_comb begin
    state_d    = state_q;
    done       = 1'b0;
    exp_par    = 1'b0;
    // The last stop bit is folded in here, because serr_q has not seen it yet.
    final_serr = serr_q | ~bit_val;
    case (pt_q)
      2'b00:   exp_par = run_par;
      2'b01:   exp_par = ~run_par;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    case (state_q)
      IDLE:   if (start_det) state_d = DATA;
      DATA:   if (bit_vld && bit_cnt == BCW'(DATA_W - 1))
                state_d = pen_q ? PARITY : STOP1;
      PARITY: if (bit_vld) state_d = STOP1;
      STOP1:  if (bit_vld) begin
                if (s2_q) state_d = STOP2;
                else begin
                  state_d = IDLE;
                  done    = 1'b1;
                end
              end
      STOP2:  if (bit_vld) begin
                state_d = IDLE;
                done    = 1'b1;
              end
      default: state_d = IDLE;
    endcase
    // Slot is free if it is empty or is being drained on this same edge.
    load = done && (!frame_vld || frame_rdy);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      run_par <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      pen_q   <= 1'b0;
      pt_q    <= 2'b00;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_det) begin
          // Frame format is latched here so that mid-frame input changes are harmless.
          pen_q   <= par_en;
          pt_q    <= par_type;
          s2_q    <= stop2;
          bit_cnt <= '0;
          run_par <= 1'b0;
          perr_q  <= 1'b0;
          serr_q  <= 1'b0;
        end
        DATA: if (bit_vld) begin
          shreg   <= {bit_val, shreg[DATA_W-1:1]};
          run_par <= run_par ^ bit_val;
          bit_cnt <= bit_cnt + BCW'(1);
        end
        PARITY: if (bit_vld) perr_q <= (bit_val != exp_par);
        STOP1, STOP2: if (bit_vld && !bit_val) serr_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_data <= '0;
      frame_vld  <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (load) begin
        frame_data <= shreg;
        frame_vld  <= 1'b1;
        par_err    <= perr_q;
        stp_err    <= final_serr;
      end else begin
        if (done) ovr_err <= 1'b1;
        if (frame_vld && frame_rdy) begin
          frame_vld <= 1'b0;
          par_err   <= 1'b0;
          stp_err   <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

`ifdef FRAME_ERR_CNT_EN
  // Only frames that are actually loaded are counted; dropped frames are not.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (cnt_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (load) begin
      if (perr_q && par_err_cnt != '1)     par_err_cnt <= par_err_cnt + CNT_W'(1);
      if (final_serr && stp_err_cnt != '1) stp_err_cnt <= stp_err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker (DATA_W=8). A table of frames
// and their expected outputs is applied in a loop. Hand-written sequences then
// cover overrun, same-edge accept, idle bit strobes and reset mid-frame. When
// FRAME_ERR_CNT_EN is defined, they also cover the counters with CNT_W=2.
module tb_uart_rx_frame_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start_det = 1'b0, bit_vld = 1'b0, bit_val = 1'b0;
  logic       par_en = 1'b0, stop2 = 1'b0, frame_rdy = 1'b0;
  logic [1:0] par_type = 2'b00;
  logic [7:0] frame_data;
  logic       frame_vld, par_err, stp_err, ovr_err, busy;
`ifdef FRAME_ERR_CNT_EN
  logic       cnt_clr = 1'b0;
  logic [1:0] par_err_cnt, stp_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_frame_checker #(.DATA_W(8), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .start_det(start_det), .bit_vld(bit_vld), .bit_val(bit_val),
    .par_en(par_en), .par_type(par_type), .stop2(stop2), .frame_data(frame_data),
    .frame_vld(frame_vld), .frame_rdy(frame_rdy), .par_err(par_err), .stp_err(stp_err),
    .ovr_err(ovr_err), .busy(busy)
`ifdef FRAME_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;   logic pe; logic [1:0] pt; logic s2;
    logic pb; logic b1; logic b2; logic gl;
    logic [7:0] ed;  logic ep; logic es;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_vld = 1'b1; bit_val = b; tick();
    bit_vld = 1'b0; tick();
  endtask

  // Sends one frame. It returns #1 after the edge that samples the last stop bit.
  task automatic send(input logic [7:0] d, input logic pe, input logic [1:0] pt,
                      input logic s2, input logic pb, input logic b1, input logic b2,
                      input logic gl, input logic rdy_last);
    par_en = pe; par_type = pt; stop2 = s2;
    start_det = 1'b1; tick(); start_det = 1'b0;
    // Scramble the format inputs; the DUT must use the values latched at start.
    par_en = ~pe; par_type = ~pt; stop2 = ~s2;
    tick();
    for (int i = 0; i < 8; i++) begin
      start_det = gl && (i == 3);
      bit_vld = 1'b1; bit_val = d[i]; tick();
      bit_vld = 1'b0; start_det = 1'b0; tick();
    end
    if (pe) send_bit(pb);
    if (s2) send_bit(b1);
    chk("busy_before_last_stop", busy, 1);
    bit_vld = 1'b1; bit_val = s2 ? b2 : b1; frame_rdy = rdy_last; tick();
    bit_vld = 1'b0; frame_rdy = 1'b0;
  endtask

  task automatic accept();
    frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
    chk("vld_after_accept", frame_vld, 0);
    chk("perr_after_accept", par_err, 0);
    chk("serr_after_accept", stp_err, 0);
  endtask

  initial begin
    //          d      pe  pt    s2  pb  b1  b2  gl   ed     ep  es
    vt[0]  = '{8'hA5, 1, 2'b00, 0,  0,  1,  1,  0,  8'hA5, 0,  0};
    vt[1]  = '{8'h01, 1, 2'b01, 0,  0,  1,  1,  0,  8'h01, 0,  0};
    vt[2]  = '{8'h01, 1, 2'b01, 0,  1,  1,  1,  0,  8'h01, 1,  0};
    vt[3]  = '{8'h01, 0, 2'b01, 0,  1,  1,  1,  0,  8'h01, 0,  0};
    vt[4]  = '{8'h3C, 1, 2'b10, 0,  0,  1,  1,  0,  8'h3C, 1,  0};
    vt[5]  = '{8'hC3, 1, 2'b11, 0,  0,  1,  1,  0,  8'hC3, 0,  0};
    vt[6]  = '{8'h5A, 0, 2'b00, 1,  0,  1,  0,  0,  8'h5A, 0,  1};
    vt[7]  = '{8'h5A, 0, 2'b00, 1,  0,  1,  1,  0,  8'h5A, 0,  0};
    vt[8]  = '{8'hFF, 0, 2'b00, 0,  0,  0,  1,  0,  8'hFF, 0,  1};
    vt[9]  = '{8'h07, 1, 2'b00, 0,  0,  1,  1,  1,  8'h07, 1,  0};
    vt[10] = '{8'h96, 1, 2'b01, 1,  1,  1,  1,  0,  8'h96, 0,  0};

    tick(); tick();
    chk("rst_vld", frame_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_flags", {par_err, stp_err, ovr_err}, 0);
    RST = 1'b1; tick();

    // bit_vld in IDLE does nothing
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("idle_bitvld_busy", busy, 0);
    chk("idle_bitvld_vld", frame_vld, 0);

    for (int v = 0; v < 11; v++) begin
      send(vt[v].d, vt[v].pe, vt[v].pt, vt[v].s2, vt[v].pb, vt[v].b1, vt[v].b2, vt[v].gl, 1'b0);
      chk($sformatf("v%0d_vld", v), frame_vld, 1);
      chk($sformatf("v%0d_data", v), frame_data, vt[v].ed);
      chk($sformatf("v%0d_perr", v), par_err, vt[v].ep);
      chk($sformatf("v%0d_serr", v), stp_err, vt[v].es);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_ovr", v), ovr_err, 0);
      tick();
      chk($sformatf("v%0d_hold", v), {frame_vld, frame_data}, {1'b1, vt[v].ed});
      accept();
    end

    // Overrun: first frame retained, second dropped, ovr_err pulses once
    send(8'hA5, 1, 2'b00, 0, 1, 1, 1, 0, 1'b0);
    chk("ovr_first_perr", par_err, 1);
    send(8'h3C, 0, 2'b00, 0, 0, 0, 1, 0, 1'b0);
    chk("ovr_pulse", ovr_err, 1);
    chk("ovr_retained_data", frame_data, 8'hA5);
    chk("ovr_retained_flags", {par_err, stp_err}, 2'b10);
    tick();
    chk("ovr_pulse_end", ovr_err, 0);
    // Accept on the completion edge: the new frame loads, no overrun
    send(8'h3C, 0, 2'b00, 0, 0, 1, 1, 0, 1'b1);
    chk("same_edge_vld", frame_vld, 1);
    chk("same_edge_data", frame_data, 8'h3C);
    chk("same_edge_perr", par_err, 0);
    chk("same_edge_ovr", ovr_err, 0);
    tick();
    chk("same_edge_ovr_later", ovr_err, 0);
    accept();

    // Reset mid-DATA with a frame pending
    send(8'h11, 0, 2'b00, 0, 0, 1, 1, 0, 1'b0);
    start_det = 1'b1; tick(); start_det = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("pre_rst_busy", busy, 1);
    #2 RST = 1'b0; #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_vld", frame_vld, 0);
    chk("rst_mid_ovr", ovr_err, 0);
    tick(); RST = 1'b1; tick();
    send(8'h69, 1, 2'b00, 0, 0, 1, 1, 0, 1'b0);
    chk("post_rst_data", frame_data, 8'h69);
    chk("post_rst_perr", par_err, 0);
    accept();

`ifdef FRAME_ERR_CNT_EN
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("cnt_clr0", par_err_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      send(8'h07, 1, 2'b00, 0, 0, 1, 1, 0, 1'b0);
      tick();
      accept();
      if (k == 1) chk("cnt_two", par_err_cnt, 2);
    end
    chk("cnt_sat", par_err_cnt, 3);
    chk("cnt_stp", stp_err_cnt, 0);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("cnt_clr", par_err_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
